// File: rtl/mult_div.sv
// mult_div: iterative 32x32 multiply / 32/32 divide unit writing a HI:LO pair.
// One radix-2 step per cycle, 32 iterations, then a sign-fix cycle.
// Signed operations run on magnitudes, and the saved signs are applied at the end.

module mult_div (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] lvalue,
  input  logic [31:0] rvalue,
  input  logic        flush,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } state_t;

  // An operand that is entirely don't-care is read as zero.
  // The ALU reads it the same way.
  localparam logic [31:0] DONT_CARE = 'x;

  state_t      state;
  state_t      state_next;

  logic [4:0]  count;
  logic        is_div;
  logic        neg_main;
  logic        neg_rem;
  logic        div_zero;
  logic [31:0] acc_hi;
  logic [31:0] acc_lo;
  logic [31:0] opnd_b;

  logic        capture;
  logic        step;
  logic        finish;

  logic        is_signed;
  logic [31:0] l_clean;
  logic [31:0] r_clean;
  logic [31:0] l_abs;
  logic [31:0] r_abs;

  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic [32:0] div_trial;
  logic        div_ok;

  logic [63:0] prod_raw;
  logic [63:0] prod_fixed;
  logic [31:0] quot_fixed;
  logic [31:0] rem_fixed;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  // State register: reset and flush both return to IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Next-state logic. Flush overrides everything, including a start in IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start && !flush) state_next = ITER;
      ITER: begin
        if (flush)
          state_next = IDLE;
        else if (count == 5'd31)
          state_next = FIX;
      end
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: busy follows the state, and these strobes steer the datapath.
  always_comb begin
    busy    = (state != IDLE);
    capture = (state == IDLE) && start && !flush;
    step    = (state == ITER) && !flush;
    finish  = (state == FIX)  && !flush;
  end

  // Operand conditioning.
  // Don't-care words are mapped to zero.
  // Signed operands are reduced to their magnitudes.
  always_comb begin
    is_signed = ~op[0];
    l_clean   = (lvalue === DONT_CARE) ? 32'd0 : lvalue;
    r_clean   = (rvalue === DONT_CARE) ? 32'd0 : rvalue;
    l_abs     = (is_signed && l_clean[31]) ? (32'd0 - l_clean) : l_clean;
    r_abs     = (is_signed && r_clean[31]) ? (32'd0 - r_clean) : r_clean;
  end

  // One iteration step.
  // Multiply: add the multiplicand into the upper half when the LSB of the
  // multiplier is set, then shift right.
  // Divide: restoring shift-subtract. The remainder sits in acc_hi, and the
  // quotient bits shift into acc_lo.
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_b} : 33'd0);
    div_shift = {acc_hi, acc_lo[31]};
    div_trial = div_shift - {1'b0, opnd_b};
    div_ok    = ~div_trial[32];
  end

  // Sign fix-up of the finished magnitudes.
  // On divide by zero the quotient is forced to all ones. The remainder
  // already equals the original dividend once its sign is restored.
  always_comb begin
    prod_raw   = {acc_hi, acc_lo};
    prod_fixed = neg_main ? (64'd0 - prod_raw) : prod_raw;
    quot_fixed = div_zero ? 32'hFFFF_FFFF : (neg_main ? (32'd0 - acc_lo) : acc_lo);
    rem_fixed  = neg_rem ? (32'd0 - acc_hi) : acc_hi;
    res_hi     = is_div ? rem_fixed  : prod_fixed[63:32];
    res_lo     = is_div ? quot_fixed : prod_fixed[31:0];
  end

  // Working registers: load at capture, advance on each ITER step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count    <= 5'd0;
      is_div   <= 1'b0;
      neg_main <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      acc_hi   <= 32'd0;
      acc_lo   <= 32'd0;
      opnd_b   <= 32'd0;
    end else if (capture) begin
      count    <= 5'd0;
      is_div   <= op[1];
      neg_main <= is_signed && (l_clean[31] ^ r_clean[31]);
      neg_rem  <= is_signed && l_clean[31];
      div_zero <= (r_clean == 32'd0);
      acc_hi   <= 32'd0;
      acc_lo   <= l_abs;
      opnd_b   <= r_abs;
    end else if (step) begin
      count <= count + 5'd1;
      if (is_div) begin
        acc_hi <= div_ok ? div_trial[31:0] : div_shift[31:0];
        acc_lo <= {acc_lo[30:0], div_ok};
      end else begin
        acc_hi <= mul_sum[32:1];
        acc_lo <= {mul_sum[0], acc_lo[31:1]};
      end
    end
  end

  // Architectural HI/LO registers and the done pulse.
  // They are written only by an unflushed FIX cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi   <= 32'd0;
      lo   <= 32'd0;
      done <= 1'b0;
    end else begin
      done <= finish;
      if (finish) begin
        hi <= res_hi;
        lo <= res_lo;
      end
    end
  end

endmodule

// File: tb/tb_mult_div.sv
// tb_mult_div: directed vectors for mult_div with a scoreboard.
// Stimulus pushes hand-computed HI:LO values into a queue. A monitor pops
// and compares an entry on every done pulse.

module tb_mult_div;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] lvalue;
  logic [31:0] rvalue;
  logic        flush;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  int          checks   = 0;
  int          failures = 0;
  logic [63:0] exp_q[$];
  string       name_q[$];
  logic [63:0] last_exp = 64'd0;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  mult_div dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .lvalue (lvalue),
    .rvalue (rvalue),
    .flush  (flush),
    .hi     (hi),
    .lo     (lo),
    .busy   (busy),
    .done   (done)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string nm, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", nm, actual, expected);
    end
  endtask

  // Issue one start pulse.
  // Returns at the first negedge after the sampling edge (k = 1).
  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] l, input logic [31:0] r,
                               input logic [63:0] expv, input string nm, input bit push);
    if (push) begin
      exp_q.push_back(expv);
      name_q.push_back(nm);
      last_exp = expv;
    end
    op     = o;
    lvalue = l;
    rvalue = r;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  // Count negedges since the start edge until done.
  // Done must first appear at negedge 34, i.e. after edge N+33.
  task automatic waitDone(input int k0);
    int k;
    k = k0;
    checkOutput("busy_during_op", 64'(busy), 64'd1);
    while (!done && k < 80) begin
      @(negedge clk);
      k++;
    end
    checkOutput("done_latency", 64'(k), 64'd34);
    checkOutput("busy_low_with_done", 64'(busy), 64'd0);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!reset && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_done: hi=%h lo=%h with no pending operation", hi, lo);
      end else begin
        checkOutput(name_q.pop_front(), {hi, lo}, exp_q.pop_front());
      end
    end
  end

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    flush  = 1'b0;
    op     = 2'b00;
    lvalue = 32'd0;
    rvalue = 32'd0;
    repeat (3) @(negedge clk);
    checkOutput("reset_hi", 64'(hi), 64'd0);
    checkOutput("reset_lo", 64'(lo), 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    reset = 1'b0;

    applyStimulus(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "multu_max", 1);
    waitDone(1);
    applyStimulus(OP_MULT, 32'hFFFF_FFF9, 32'd3, 64'hFFFF_FFFF_FFFF_FFEB, "mult_m7x3", 1);
    waitDone(1);
    applyStimulus(OP_DIV, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, "div_m7d2", 1);
    waitDone(1);
    applyStimulus(OP_DIVU, 32'd7, 32'd0, 64'h0000_0007_FFFF_FFFF, "divu_7d0", 1);
    waitDone(1);
    applyStimulus(OP_DIV, 32'hFFFF_FFF9, 32'd0, 64'hFFFF_FFF9_FFFF_FFFF, "div_m7d0", 1);
    waitDone(1);
    applyStimulus(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, "div_min_m1", 1);
    waitDone(1);
    applyStimulus(OP_MULT, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, "mult_min_sq", 1);
    waitDone(1);
    applyStimulus(OP_MULTU, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, "multu_2p32", 1);
    waitDone(1);
    applyStimulus(OP_DIVU, 32'd100, 32'd7, 64'h0000_0002_0000_000E, "divu_100d7", 1);
    waitDone(1);

    // Flush in mid-divide: the op is dropped and HI/LO keep their values
    @(negedge clk);
    applyStimulus(OP_DIVU, 32'd200, 32'd3, 64'd0, "flushed", 0);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checkOutput("flush_busy", 64'(busy), 64'd0);
    checkOutput("flush_hold", {hi, lo}, last_exp);
    applyStimulus(OP_MULT, 32'd6, 32'hFFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFF4, "after_flush", 1);
    waitDone(1);

    // Flush and start in the same IDLE cycle: flush wins
    @(negedge clk);
    op     = OP_MULTU;
    lvalue = 32'd9;
    rvalue = 32'd9;
    start  = 1'b1;
    flush  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    checkOutput("flush_start_busy", 64'(busy), 64'd0);

    // A start while busy is ignored
    applyStimulus(OP_DIVU, 32'd100, 32'd7, 64'h0000_0002_0000_000E, "ignore_busy_start", 1);
    repeat (4) @(negedge clk);
    op     = OP_MULTU;
    lvalue = 32'd1234;
    rvalue = 32'd5678;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone(6);

    // A start in the done cycle is accepted
    applyStimulus(OP_MULT, 32'hFFFF_FFF9, 32'd3, 64'hFFFF_FFFF_FFFF_FFEB, "start_in_done", 1);
    waitDone(1);

    // Reset pulse between clock edges in mid-operation
    @(negedge clk);
    applyStimulus(OP_MULTU, 32'd5, 32'd5, 64'd0, "reset_killed", 0);
    repeat (18) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("midreset_hi", 64'(hi), 64'd0);
    checkOutput("midreset_lo", 64'(lo), 64'd0);
    checkOutput("midreset_busy", 64'(busy), 64'd0);
    #1 reset = 1'b0;
    last_exp = 64'd0;
    repeat (40) @(negedge clk);
    checkOutput("no_done_after_reset", 64'(done), 64'd0);

    // A don't-care multiplier reads as zero
    applyStimulus(OP_MULT, 32'd5, 'x, 64'd0, "dont_care_rvalue", 1);
    rvalue = 32'd0;
    waitDone(1);

    @(negedge clk);
    checkOutput("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult_div.md
MULT_DIV -- requirements
Module: mult_div

Interface
REQ-001 No parameters; all widths SHALL be fixed at 32-bit operands and a 64-bit HI:LO result.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 start  input  1  request a new operation; sampled on clk edge.
REQ-005 op  input  2  00 mult, 01 multu, 10 div, 11 divu; sampled with start.
REQ-006 lvalue  input  32  multiplicand / dividend, same source as the ALU lvalue.
REQ-007 rvalue  input  32  multiplier / divisor, same source as the ALU rvalue.
REQ-008 flush  input  1  abort any in-flight operation (branch squash).
REQ-009 hi  output  32  HI register (mult: upper product; div: remainder).
REQ-010 lo  output  32  LO register (mult: lower product; div: quotient).
REQ-011 busy  output  1  operation in flight; the hazard unit stalls mfhi/mflo/mult/div while high.
REQ-012 done  output  1  one-cycle pulse; hi/lo updated on the same edge that raises it.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, ITER, FIX.
REQ-014 In IDLE with start=1 and flush=0, the block SHALL capture operands and op, set count=0, and enter ITER.
REQ-015 At capture, an operand equal to the codebase don't-care word (all bits X) SHALL be treated as 0, the same convention the ALU uses.
REQ-016 For signed ops, the block SHALL capture absolute values and record the result signs: product sign = sign(l) XOR sign(r); remainder sign = sign(l).
REQ-017 ITER SHALL perform one radix-2 step per cycle: shift-add for multiply, restoring shift-subtract for divide.
REQ-018 ITER SHALL run exactly 32 cycles (count 0..31), then enter FIX.
REQ-019 FIX SHALL apply sign correction (two's-complement negate), write hi/lo, pulse done for one cycle, and return to IDLE.
REQ-020 Latency: with start sampled at edge N, hi/lo and done SHALL update at edge N+33, and done SHALL be high only during the cycle after edge N+33.
REQ-021 busy SHALL be high from edge N through edge N+33, deasserting on the same edge that asserts done.
REQ-022 start SHALL be ignored while busy=1; hi/lo are never written mid-operation.
REQ-023 start SHALL be accepted in the cycle where done=1, because the FSM is back in IDLE.
REQ-024 flush=1 in any state SHALL return the FSM to IDLE on the next edge, with hi/lo unchanged, no done pulse, and busy=0.
REQ-025 flush and start asserted in the same IDLE cycle: flush SHALL win and no operation starts.
REQ-026 Signed division SHALL truncate the quotient toward zero; the remainder takes the sign of the dividend.
REQ-027 Divide by zero SHALL give lo=32'hFFFFFFFF and hi=dividend (raw, before sign handling), with no exception and the normal 33-cycle latency.
REQ-028 div of 32'h80000000 by 32'hFFFFFFFF SHALL give lo=32'h80000000 and hi=0.
REQ-029 mult/multu SHALL produce the full 64-bit product as {hi,lo}, with no overflow flag.

Reset
REQ-030 Asserting reset SHALL immediately force state=IDLE, count=0, hi=0, lo=0, busy=0, and done=0, regardless of clk.
REQ-031 Reset asserted mid-operation SHALL discard the operation, with no done pulse after release.
REQ-032 After reset deasserts, the first start SHALL be accepted on the next rising edge.

Verification
REQ-033 multu 32'hFFFFFFFF x 32'hFFFFFFFF -> at edge N+33: hi=32'hFFFFFFFE, lo=32'h00000001, done pulses once.
REQ-034 mult -7 x 3 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFEB; busy high for exactly 34 edges' span (N..N+33).
REQ-035 div -7 / 2 -> lo=32'hFFFFFFFD (-3), hi=32'hFFFFFFFF (-1); divu 7 / 0 -> lo=32'hFFFFFFFF, hi=7.
REQ-036 start div, assert flush at N+10 -> busy=0 at N+11, no done, hi/lo keep prior values; new start at N+12 completes at N+45.
REQ-037 start during busy (N+5) with different operands -> ignored, result matches the original operands; start in the done cycle -> accepted, second done 33 edges later.
REQ-038 reset pulse at N+20 between clk edges -> hi=lo=0 and busy=0 immediately; no done afterwards; don't-care operand on rvalue with mult -> hi=lo=0.
